sub16u_lsb_approx_pipe: RTL and testbench

//  Two-stage pipelined approximate unsigned subtractor. It is the inverse-direction companion of the

---
 rtl/sub_approx_pkg.sv | 31 +++
 rtl/sub_exact_upper.sv | 28 ++
 rtl/sub16u_lsb_approx_pipe.sv | 128 ++++++++++++
 tb/tb_sub16u_lsb_approx_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_approx_pkg.sv
// Shared definitions for the approximate subtractor family: default
// configuration, the LSB-width derivation and the per-bit approximation rules.
package sub_approx_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_EXACT_BITS = 4;
    localparam int DEF_TAG_W      = 4;
    localparam int DEF_LSB_BITS   = DEF_WIDTH - DEF_EXACT_BITS;

    // Upper-part result at the default configuration: borrow-out plus exact difference.
    typedef struct packed {
        logic                      bout;
        logic [DEF_EXACT_BITS-1:0] diff;
    } sub_res_t;

    // Number of approximated low bits for a given operand width / exact split.
    function automatic int lsb_bits(input int width, input int exact_bits);
        return width - exact_bits;
    endfunction

    // One bit of the borrow-free lower difference: keep A's bit only where B is clear.
    function automatic logic approx_lsb(input logic a, input logic b);
        return a & ~b;
    endfunction

    // Borrow fed into the exact part, guessed from the top approximated bit only.
    function automatic logic borrow_guess(input logic a_msb, input logic b_msb);
        return ~a_msb & b_msb;
    endfunction

endpackage

// File: rtl/sub_exact_upper.sv
// Combinational exact ripple-borrow subtractor with borrow-in and borrow-out.
module sub_exact_upper #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic [W-1:0] diff,
    output logic         bout
);

    // brw[i] is the borrow entering bit i; brw[W] leaves the top bit.
    logic [W:0] brw;

    assign brw[0] = bin;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_bit
            // Full-subtractor cell: borrow when b+borrow exceeds a at this bit.
            assign diff[gi]    = a[gi] ^ b[gi] ^ brw[gi];
            assign brw[gi + 1] = (~a[gi] & b[gi]) | (~(a[gi] ^ b[gi]) & brw[gi]);
        end
    endgenerate

    assign bout = brw[W];

endmodule

// File: rtl/sub16u_lsb_approx_pipe.sv
// Two-stage approximate unsigned subtractor on valid/ready streams.
// Stage 1 forms the borrow-free low difference and the borrow guess; stage 2
// runs the exact upper subtraction and presents {borrow_out, difference}.
module sub16u_lsb_approx_pipe
    import sub_approx_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int EXACT_BITS = DEF_EXACT_BITS,
    parameter int TAG_W      = DEF_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_d,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LSB_BITS = lsb_bits(WIDTH, EXACT_BITS);

    // Stage 1 registers
    logic                  s1_valid_reg;
    logic [LSB_BITS-1:0]   s1_lsb_reg;
    logic                  s1_bin_reg;
    logic [EXACT_BITS-1:0] s1_a_hi_reg;
    logic [EXACT_BITS-1:0] s1_b_hi_reg;
    logic [TAG_W-1:0]      s1_tag_reg;

    // Stage 2 (output) registers
    logic                  out_valid_reg;
    logic [WIDTH:0]        out_d_reg;
    logic [TAG_W-1:0]      out_tag_reg;

    // Handshake
    logic s2_free;
    logic s1_adv;
    logic accept;

    // Combinational stage results
    logic [LSB_BITS-1:0]   lsb_next;
    logic                  bin_next;
    logic [EXACT_BITS-1:0] hi_diff;
    logic                  hi_bout;

    assign s2_free  = !out_valid_reg || out_ready;
    assign s1_adv   = s1_valid_reg && s2_free;
    assign in_ready = !s1_valid_reg || s2_free;
    assign accept   = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LSB_BITS; gi++) begin : g_lsb
            assign lsb_next[gi] = approx_lsb(in_a[gi], in_b[gi]);
        end
    endgenerate

    assign bin_next = borrow_guess(in_a[LSB_BITS-1], in_b[LSB_BITS-1]);

    // Stage 1 occupancy: filled on accept, emptied when it advances with nothing new behind it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
        end else if (s1_adv) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 1 data: loads only on accept so idle cycles do not toggle the registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_lsb_reg  <= '0;
            s1_bin_reg  <= 1'b0;
            s1_a_hi_reg <= '0;
            s1_b_hi_reg <= '0;
            s1_tag_reg  <= '0;
        end else if (accept) begin
            s1_lsb_reg  <= lsb_next;
            s1_bin_reg  <= bin_next;
            s1_a_hi_reg <= in_a[WIDTH-1:LSB_BITS];
            s1_b_hi_reg <= in_b[WIDTH-1:LSB_BITS];
            s1_tag_reg  <= in_tag;
        end
    end

    sub_exact_upper #(
        .W(EXACT_BITS)
    ) u_upper (
        .a   (s1_a_hi_reg),
        .b   (s1_b_hi_reg),
        .bin (s1_bin_reg),
        .diff(hi_diff),
        .bout(hi_bout)
    );

    // Output occupancy: set when stage 1 advances, cleared on handoff with no replacement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
        end else if (s1_adv) begin
            out_valid_reg <= 1'b1;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Output data: loads only when stage 1 advances, so it is held stable under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_d_reg   <= '0;
            out_tag_reg <= '0;
        end else if (s1_adv) begin
            out_d_reg   <= {hi_bout, hi_diff, s1_lsb_reg};
            out_tag_reg <= s1_tag_reg;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_d     = out_d_reg;
    assign out_tag   = out_tag_reg;

endmodule

// File: tb/tb_sub16u_lsb_approx_pipe.sv
// Self-checking bench: directed cases plus randomized traffic with random
// back-pressure, scored against an arithmetic reference model.
module tb_sub16u_lsb_approx_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_d;
    logic [3:0]  out_tag;

    sub16u_lsb_approx_pipe #(
        .WIDTH     (16),
        .EXACT_BITS(4),
        .TAG_W     (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_d    (out_d),
        .out_tag  (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] d;
        logic [3:0]  tag;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   n_out    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: low bits keep A where B is clear; upper part is plain integer
    // subtraction of the high nibbles minus the guessed borrow, wrapped mod 16.
    function automatic logic [16:0] model_d(input logic [15:0] a, input logic [15:0] b);
        logic [11:0] lo;
        int          bin;
        int          hi;
        logic        bout;
        logic [3:0]  hi4;
        lo   = a[11:0] & ~b[11:0];
        bin  = (a[11] == 1'b0 && b[11] == 1'b1) ? 1 : 0;
        hi   = int'(a / 16'd4096) - int'(b / 16'd4096) - bin;
        bout = (hi < 0);
        if (hi < 0) hi = hi + 16;
        hi4  = hi[3:0];
        return {bout, hi4, lo};
    endfunction

    // One cycle: drive at edge+1, observe at edge+2, then advance to next edge+1.
    task automatic cycle(input logic v, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] tag, input logic rdy, input bit lat,
                         output bit acc);
        exp_t e;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
        out_ready = rdy;
        #1;
        acc = v && in_ready;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_out", {31'b0, out_valid}, 32'd0);
            end else begin
                check_eq("out_d", {15'b0, out_d}, {15'b0, exp_q[0].d});
                check_eq("out_tag", {28'b0, out_tag}, {28'b0, exp_q[0].tag});
                if (out_ready) begin
                    e = exp_q.pop_front();
                    if (e.chk_lat) check_eq("latency", cyc - e.acc_cyc, 32'd2);
                    $display("out #%0d tag=%0h d=%05h", n_out, out_tag, out_d);
                    n_out++;
                end
            end
        end
        if (acc) begin
            e.d = model_d(a, b);
            e.tag = tag;
            e.acc_cyc = cyc;
            e.chk_lat = lat;
            exp_q.push_back(e);
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit acc;
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            cycle(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, acc);
            guard++;
        end
        check_eq("drain_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] t5_a [3];
    logic [15:0] t5_b [3];

    initial begin
        bit acc;
        int k;
        logic [15:0] ra, rb;
        longint err_sum;
        int     wce;
        int     exact, approx, err;
        logic [16:0] md;

        rst = 1'b1; in_valid = 0; in_a = 0; in_b = 0; in_tag = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("rst_out_d", {15'b0, out_d}, 32'd0);
        check_eq("rst_out_tag", {28'b0, out_tag}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed vectors, no stall, latency checked
        cycle(1'b1, 16'h1234, 16'h0234, 4'h5, 1'b1, 1'b1, acc);
        cycle(1'b1, 16'h0000, 16'h0800, 4'h6, 1'b1, 1'b1, acc);
        cycle(1'b1, 16'h0800, 16'h0000, 4'h7, 1'b1, 1'b1, acc);
        cycle(1'b1, 16'h0000, 16'h0001, 4'h8, 1'b1, 1'b1, acc);
        drain();
        check_eq("model_t1", model_d(16'h1234, 16'h0234), 32'h01000);
        check_eq("model_t2", model_d(16'h0000, 16'h0800), 32'h1F000);

        // Back-to-back 8 vectors, tags 0..7
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 16'($urandom), 16'($urandom), 4'(i), 1'b1, 1'b1, acc);
            check_eq("b2b_accept", {31'b0, acc}, 32'd1);
        end
        drain();

        // Stall: out_ready low for 5 cycles with 3 vectors offered
        t5_a[0] = 16'hA5A5; t5_b[0] = 16'h1111;
        t5_a[1] = 16'h0F00; t5_b[1] = 16'hF0FF;
        t5_a[2] = 16'hFFFF; t5_b[2] = 16'h0001;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, t5_a[k], t5_b[k], 4'(k + 9), 1'b0, 1'b0, acc);
            if (acc && k < 2) k++;
            else if (acc) k++;
        end
        check_eq("stall_accepted", k, 32'd2);
        check_eq("stall_in_ready", {31'b0, in_ready}, 32'd0);
        while (k < 3) begin
            cycle(1'b1, t5_a[k], t5_b[k], 4'(k + 9), 1'b1, 1'b0, acc);
            if (acc) k++;
        end
        drain();

        // Reset with both stages full
        cycle(1'b1, 16'h4321, 16'h1234, 4'hC, 1'b0, 1'b0, acc);
        cycle(1'b1, 16'h8765, 16'h5678, 4'hD, 1'b0, 1'b0, acc);
        check_eq("full_out_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_out_valid", {31'b0, out_valid}, 32'd0);
        check_eq("arst_out_d", {15'b0, out_d}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, acc);

        // Randomized traffic with random back-pressure and boundary-biased operands
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 5))
                0: ra = 16'h0000;
                1: ra = 16'hFFFF;
                2: ra = 16'h0800;
                default: ra = 16'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: rb = 16'h0000;
                1: rb = 16'hFFFF;
                2: rb = 16'h0800;
                default: rb = 16'($urandom);
            endcase
            cycle(($urandom_range(0, 3) != 0), ra, rb, 4'(i),
                  ($urandom_range(0, 3) != 0), 1'b0, acc);
        end
        drain();

        // Error statistics of the approximation over random vectors
        err_sum = 0;
        wce = 0;
        for (int i = 0; i < 1000000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            md = model_d(ra, rb);
            exact  = int'(ra) - int'(rb);
            approx = int'(md[15:0]) - (md[16] ? 65536 : 0);
            err = (approx > exact) ? approx - exact : exact - approx;
            err_sum += err;
            if (err > wce) wce = err;
        end
        $display("error stats: MAE=%0d.%03d WCE=%0d over 1000000 vectors",
                 err_sum / 1000000, (err_sum % 1000000) / 1000, wce);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
